// File: rtl/fetch_ghr_checkpoint.sv
// Speculative/architectural global history register with per-branch checkpoint allocation and recovery.
// Optional macro FETCH_GHR_STALL_STAT_EN adds a saturating count of cycles spent waiting for a checkpoint.
module fetch_ghr_checkpoint #(
    parameter int GHR_WIDTH           = 16,
    parameter int CHECKPOINT_ID_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fetch_branch_valid,
    input  logic                           fetch_branch_taken,
    output logic                           ghr_fetch_stall,
    output logic [GHR_WIDTH-1:0]           ghr_fetch_value,
    output logic [CHECKPOINT_ID_WIDTH-1:0] ghr_fetch_cp_id,
    input  logic [CHECKPOINT_ID_WIDTH-1:0] cpbuf_fetch_new_id,
    input  logic                           cpbuf_fetch_new_id_valid,
    output logic                           fetch_cpbuf_push,
    output logic [GHR_WIDTH-1:0]           fetch_cpbuf_ghr,
    input  logic                           exbru_ghr_restore,
    input  logic [GHR_WIDTH-1:0]           exbru_ghr_data,
    input  logic                           exbru_taken,
    input  logic                           commit_ghr_update,
    input  logic                           commit_taken,
    input  logic                           commit_ghr_flush
`ifdef FETCH_GHR_STALL_STAT_EN
    ,
    output logic [31:0]                    ghr_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        WAIT_CP = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [GHR_WIDTH-1:0]   spec_ghr_q, spec_ghr_d;
    logic [GHR_WIDTH-1:0]   arch_ghr_q, arch_ghr_d;
    logic                   accept;

    assign ghr_fetch_value = spec_ghr_q;
    assign fetch_cpbuf_ghr = spec_ghr_q;
    assign ghr_fetch_cp_id = cpbuf_fetch_new_id;

    always_comb begin
        state_d          = state_q;
        spec_ghr_d       = spec_ghr_q;
        arch_ghr_d       = arch_ghr_q;
        accept           = 1'b0;
        fetch_cpbuf_push = 1'b0;
        ghr_fetch_stall  = 1'b0;

        if (commit_ghr_update) begin
            arch_ghr_d = (arch_ghr_q << 1) | GHR_WIDTH'(commit_taken);
        end

        unique case (state_q)
            NORMAL: begin
                accept = fetch_branch_valid && cpbuf_fetch_new_id_valid;
                if (fetch_branch_valid && !cpbuf_fetch_new_id_valid) begin
                    state_d = WAIT_CP;
                end
            end
            WAIT_CP: begin
                if (cpbuf_fetch_new_id_valid) begin
                    state_d = NORMAL;
                end
            end
            RECOVER: state_d = NORMAL;
            default: state_d = NORMAL;
        endcase

        // Flush restores from the post-commit architectural history.
        if (commit_ghr_flush) begin
            accept     = 1'b0;
            spec_ghr_d = arch_ghr_d;
            state_d    = RECOVER;
        end else if (exbru_ghr_restore) begin
            accept     = 1'b0;
            spec_ghr_d = (exbru_ghr_data << 1) | GHR_WIDTH'(exbru_taken);
            state_d    = RECOVER;
        end else if (accept) begin
            spec_ghr_d = (spec_ghr_q << 1) | GHR_WIDTH'(fetch_branch_taken);
        end

        fetch_cpbuf_push = accept;
        ghr_fetch_stall  = (state_q == RECOVER) || (fetch_branch_valid && !accept);

        if (rst) begin
            fetch_cpbuf_push = 1'b0;
            ghr_fetch_stall  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= NORMAL;
            spec_ghr_q <= '0;
            arch_ghr_q <= '0;
        end else begin
            state_q    <= state_d;
            spec_ghr_q <= spec_ghr_d;
            arch_ghr_q <= arch_ghr_d;
        end
    end

`ifdef FETCH_GHR_STALL_STAT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == WAIT_CP) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ghr_stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ghr_checkpoint.sv
// Scoreboard bench for fetch_ghr_checkpoint: directed scenarios then random traffic vs a history model.
module tb_fetch_ghr_checkpoint;
    localparam int W   = 16;
    localparam int IDW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           fetch_branch_valid, fetch_branch_taken;
    logic           ghr_fetch_stall;
    logic [W-1:0]   ghr_fetch_value;
    logic [IDW-1:0] ghr_fetch_cp_id;
    logic [IDW-1:0] cpbuf_fetch_new_id;
    logic           cpbuf_fetch_new_id_valid;
    logic           fetch_cpbuf_push;
    logic [W-1:0]   fetch_cpbuf_ghr;
    logic           exbru_ghr_restore;
    logic [W-1:0]   exbru_ghr_data;
    logic           exbru_taken;
    logic           commit_ghr_update, commit_taken, commit_ghr_flush;
`ifdef FETCH_GHR_STALL_STAT_EN
    logic [31:0]    ghr_stall_cycles;
`endif

    always #5 clk = ~clk;

    fetch_ghr_checkpoint #(.GHR_WIDTH(W), .CHECKPOINT_ID_WIDTH(IDW)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .fetch_branch_valid       (fetch_branch_valid),
        .fetch_branch_taken       (fetch_branch_taken),
        .ghr_fetch_stall          (ghr_fetch_stall),
        .ghr_fetch_value          (ghr_fetch_value),
        .ghr_fetch_cp_id          (ghr_fetch_cp_id),
        .cpbuf_fetch_new_id       (cpbuf_fetch_new_id),
        .cpbuf_fetch_new_id_valid (cpbuf_fetch_new_id_valid),
        .fetch_cpbuf_push         (fetch_cpbuf_push),
        .fetch_cpbuf_ghr          (fetch_cpbuf_ghr),
        .exbru_ghr_restore        (exbru_ghr_restore),
        .exbru_ghr_data           (exbru_ghr_data),
        .exbru_taken              (exbru_taken),
        .commit_ghr_update        (commit_ghr_update),
        .commit_taken             (commit_taken),
        .commit_ghr_flush         (commit_ghr_flush)
`ifdef FETCH_GHR_STALL_STAT_EN
        ,
        .ghr_stall_cycles         (ghr_stall_cycles)
`endif
    );

    typedef struct {
        logic [W-1:0]   ghr;
        logic [IDW-1:0] id;
    } push_t;

    typedef struct {
        bit           stall;
        bit           push;
        bit           chk_val;
        logic [W-1:0] val;
    } cyc_t;

    push_t push_q[$];
    cyc_t  cyc_q[$];
    push_t mon_p;
    cyc_t  mon_c;

    int checks = 0;
    int passes = 0;

    // Reference model: histories as plain vectors, pipeline condition as two flags.
    logic [W-1:0] m_spec, m_arch;
    bit           m_wait, m_recover;
    int           m_stat;

    function automatic logic [W-1:0] shl(input logic [W-1:0] v, input bit b);
        logic [W-1:0] r;
        r = {v[W-2:0], b};
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mon_c = cyc_q.pop_front();
            check("stall", 32'(ghr_fetch_stall), 32'(mon_c.stall));
            check("push", 32'(fetch_cpbuf_push), 32'(mon_c.push));
            if (mon_c.chk_val) check("ghr_value", 32'(ghr_fetch_value), 32'(mon_c.val));
            if (fetch_cpbuf_push === 1'b1) begin
                if (push_q.size() == 0) begin
                    checks++;
                    $display("FAIL push_unexpected: got push with ghr 0x%0h expected none", fetch_cpbuf_ghr);
                end else begin
                    mon_p = push_q.pop_front();
                    check("snapshot", 32'(fetch_cpbuf_ghr), 32'(mon_p.ghr));
                    check("cp_id", 32'(ghr_fetch_cp_id), 32'(mon_p.id));
                end
            end
        end
    end

    task automatic step(input bit r, input bit v, input bit t, input bit idv, input logic [IDW-1:0] id,
                        input bit rs, input logic [W-1:0] rd, input bit rt,
                        input bit cu, input bit ct, input bit fl, output bit acc);
        cyc_t         c;
        push_t        p;
        logic [W-1:0] na;
        rst = r; fetch_branch_valid = v; fetch_branch_taken = t;
        cpbuf_fetch_new_id_valid = idv; cpbuf_fetch_new_id = id;
        exbru_ghr_restore = rs; exbru_ghr_data = rd; exbru_taken = rt;
        commit_ghr_update = cu; commit_taken = ct; commit_ghr_flush = fl;
        acc = 1'b0;
        if (r) begin
            c.stall = 1'b0; c.push = 1'b0; c.chk_val = 1'b0; c.val = '0;
            m_spec = '0; m_arch = '0; m_wait = 1'b0; m_recover = 1'b0; m_stat = 0;
        end else begin
            acc = !m_wait && !m_recover && v && idv && !rs && !fl;
            c.stall = m_recover || (v && !acc);
            c.push = acc; c.chk_val = 1'b1; c.val = m_spec;
            if (acc) begin
                p.ghr = m_spec; p.id = id;
                push_q.push_back(p);
            end
            if (m_wait) m_stat++;
            na = cu ? shl(m_arch, ct) : m_arch;
            if (fl)       m_spec = na;
            else if (rs)  m_spec = shl(rd, rt);
            else if (acc) m_spec = shl(m_spec, t);
            m_arch = na;
            if (fl || rs)       begin m_recover = 1'b1; m_wait = 1'b0; end
            else if (m_recover) m_recover = 1'b0;
            else if (m_wait)    m_wait = !idv;
            else                m_wait = v && !idv;
        end
        cyc_q.push_back(c);
        @(posedge clk);
        #1;
    endtask

    task automatic br(input bit t, input bit idv, input logic [IDW-1:0] id);
        bit a;
        step(1'b0, 1'b1, t, idv, id, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic do_reset();
        bit a;
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, a);
        step(1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, a);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit           a, pend, pt, idv, rs, fl, cu;
        rst = 1'b1; fetch_branch_valid = 1'b0; fetch_branch_taken = 1'b0;
        cpbuf_fetch_new_id = '0; cpbuf_fetch_new_id_valid = 1'b0;
        exbru_ghr_restore = 1'b0; exbru_ghr_data = '0; exbru_taken = 1'b0;
        commit_ghr_update = 1'b0; commit_taken = 1'b0; commit_ghr_flush = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then taken/not/taken all accepted: snapshots 0,1,2 and history 0x5.
        do_reset();
        check("reset_value", 32'(ghr_fetch_value), 32'h0);
        br(1'b1, 1'b1, 4'd1);
        br(1'b0, 1'b1, 4'd2);
        br(1'b1, 1'b1, 4'd3);
        check("three_branches", 32'(ghr_fetch_value), 32'h0005);

        // Saturated history: MSB falls off.
        do_reset();
        for (int i = 0; i < 16; i++) br(1'b1, 1'b1, IDW'(i));
        check("all_ones", 32'(ghr_fetch_value), 32'hFFFF);
        br(1'b0, 1'b1, 4'd9);
        check("msb_discard", 32'(ghr_fetch_value), 32'hFFFE);

        // Checkpoint buffer full for three cycles: four stall cycles then one push of 0x00FF.
        do_reset();
        for (int i = 0; i < 8; i++) br(1'b1, 1'b1, IDW'(i));
        check("preload_ff", 32'(ghr_fetch_value), 32'h00FF);
        for (int i = 0; i < 3; i++) br(1'b1, 1'b0, 4'd7);
        br(1'b1, 1'b1, 4'd7);
        br(1'b1, 1'b1, 4'd7);
        check("after_wait_push", 32'(ghr_fetch_value), 32'h01FF);

        // Five cycles in WAIT_CP for the stall statistic.
        do_reset();
        for (int i = 0; i < 5; i++) br(1'b0, 1'b0, 4'd3);
        br(1'b0, 1'b1, 4'd3);
`ifdef FETCH_GHR_STALL_STAT_EN
        check("stall_cycles", ghr_stall_cycles, 32'd5);
`endif
        br(1'b0, 1'b1, 4'd3);
        do_reset();
`ifdef FETCH_GHR_STALL_STAT_EN
        check("stall_cycles_reset", ghr_stall_cycles, 32'd0);
`endif

        // Misprediction restore with a branch presented the same cycle.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, a);
        check("restore_value", 32'(ghr_fetch_value), 32'h2469);
        br(1'b0, 1'b1, 4'd5);
        br(1'b0, 1'b1, 4'd5);

        // Commit shift, flush and restore together: flush wins with post-commit history.
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, a);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, a);
        step(1'b0, 1'b1, 1'b1, 1'b1, '0, 1'b1, 16'hABCD, 1'b1, 1'b1, 1'b0, 1'b1, a);
        check("flush_value", 32'(ghr_fetch_value), 32'h0006);
        step(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, a);
        check("arch_value", 32'(ghr_fetch_value), 32'h0006);

        // Random traffic; a presented branch stays until accepted or redirected.
        do_reset();
        pend = 1'b0; pt = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                pend = 1'b0;
            end else begin
                if (!pend && $urandom_range(0, 2) != 0) begin
                    pend = 1'b1;
                    pt = 1'($urandom);
                end
                idv = ($urandom_range(0, 9) < 7);
                rs  = ($urandom_range(0, 19) == 0);
                fl  = ($urandom_range(0, 29) == 0);
                cu  = ($urandom_range(0, 3) == 0);
                step(1'b0, pend, pt, idv, IDW'($urandom), rs, W'($urandom), 1'($urandom),
                     cu, 1'($urandom), fl, a);
                if (a || rs || fl) pend = 1'b0;
            end
        end

        check("scoreboard_drained", 32'(push_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ghr_checkpoint.md
FETCH_GHR_CHECKPOINT -- requirements
Module: fetch_ghr_checkpoint

Interface
REQ-001 SHALL have parameter GHR_WIDTH, default 16, global history register width in bits (range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port fetch_branch_valid  input  1  fetch presents a predicted conditional branch; held stable until accepted.
REQ-005 SHALL have port fetch_branch_taken  input  1  predicted direction of the presented branch.
REQ-006 SHALL have port ghr_fetch_stall  output  1  branch not accepted this cycle.
REQ-007 SHALL have port ghr_fetch_value  output  GHR_WIDTH  current speculative GHR, used by the predictor.
REQ-008 SHALL have port ghr_fetch_cp_id  output  CHECKPOINT_ID_WIDTH  checkpoint id assigned to the accepted branch.
REQ-009 SHALL have port cpbuf_fetch_new_id  input  CHECKPOINT_ID_WIDTH  next free checkpoint id from the checkpoint buffer.
REQ-010 SHALL have port cpbuf_fetch_new_id_valid  input  1  checkpoint buffer not full.
REQ-011 SHALL have port fetch_cpbuf_push  output  1  allocate one checkpoint this cycle.
REQ-012 SHALL have port fetch_cpbuf_ghr  output  GHR_WIDTH  GHR snapshot written into the allocated checkpoint.
REQ-013 SHALL have port exbru_ghr_restore  input  1  branch unit reports a misprediction.
REQ-014 SHALL have port exbru_ghr_data  input  GHR_WIDTH  GHR snapshot read back from the mispredicted branch's checkpoint.
REQ-015 SHALL have port exbru_taken  input  1  resolved direction of the mispredicted branch.
REQ-016 SHALL have port commit_ghr_update  input  1  one branch retires this cycle.
REQ-017 SHALL have port commit_taken  input  1  resolved direction of the retiring branch.
REQ-018 SHALL have port commit_ghr_flush  input  1  pipeline flush (exception/interrupt); same cycle as commit_cpbuf_flush.

Function
REQ-019 SHALL hold spec_ghr (speculative) and arch_ghr (architectural) registers, each GHR_WIDTH bits wide; ghr_fetch_value = spec_ghr.
REQ-020 SHALL implement FSM states NORMAL, WAIT_CP and RECOVER.
REQ-021 SHALL accept a branch in NORMAL when fetch_branch_valid=1 and cpbuf_fetch_new_id_valid=1; accept is combinational, zero-latency.
REQ-022 SHALL, on accept, assert fetch_cpbuf_push=1 with fetch_cpbuf_ghr=spec_ghr (pre-branch value) and ghr_fetch_cp_id=cpbuf_fetch_new_id in the same cycle.
REQ-023 SHALL, on accept, load spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], fetch_branch_taken} on the next edge.
REQ-024 SHALL, in NORMAL with fetch_branch_valid=1 and cpbuf_fetch_new_id_valid=0, assert ghr_fetch_stall=1 and move to WAIT_CP; push=0.
REQ-025 SHALL, in WAIT_CP, keep stall=1 and push=0, and return to NORMAL on the cycle after cpbuf_fetch_new_id_valid=1; the branch is accepted in NORMAL.
REQ-026 SHALL, on exbru_ghr_restore=1, load spec_ghr <= {exbru_ghr_data[GHR_WIDTH-2:0], exbru_taken}, force push=0 that cycle, and enter RECOVER.
REQ-027 SHALL, in RECOVER, assert stall=1 for exactly one cycle, then go to NORMAL.
REQ-028 SHALL, on commit_ghr_update=1, load arch_ghr <= {arch_ghr[GHR_WIDTH-2:0], commit_taken}.
REQ-029 SHALL, on commit_ghr_flush=1, load spec_ghr <= arch_ghr (after any same-cycle commit shift is applied), force push=0, and enter RECOVER.
REQ-030 SHALL apply spec_ghr priority commit_ghr_flush > exbru_ghr_restore > accept; arch_ghr updates regardless of flush or restore.
REQ-031 SHALL assert ghr_fetch_stall only when fetch_branch_valid=1 or the FSM is in RECOVER.
REQ-032 SHALL drive ghr_fetch_cp_id = cpbuf_fetch_new_id at all times; the value is meaningful only when push=1.

Reset
REQ-033 SHALL, while rst=1, clear spec_ghr and arch_ghr to 0, set the FSM to NORMAL, and drive push=0 and stall=0.
REQ-034 SHALL give rst priority over every other input, including a reset in WAIT_CP or RECOVER.

Configuration
REQ-035 SHALL, with macro FETCH_GHR_STALL_STAT_EN defined, add output ghr_stall_cycles (32 bits), counting cycles in WAIT_CP, cleared by rst, saturating at all-ones.
REQ-036 SHALL, without FETCH_GHR_STALL_STAT_EN, omit the port and counter; all other behaviour is identical.

Verification
REQ-037 SHALL cover: reset, then branches taken,not,taken, all accepted -> pushes snapshot 0x0000,0x0001,0x0002; spec_ghr=0x0005.
REQ-038 SHALL cover: spec_ghr=0x00FF, id_valid=0 for 3 cycles with branch pending -> stall=1 for 4 cycles, push=0, then one push with snapshot 0x00FF.
REQ-039 SHALL cover: exbru_ghr_restore=1, data=0x1234, taken=1, with a simultaneous fetch branch -> push=0; next spec_ghr=0x2469; stall=1 one cycle.
REQ-040 SHALL cover: arch_ghr=0x0003, same cycle commit_ghr_update=1 taken=0 plus flush plus restore -> spec_ghr=arch_ghr=0x0006.
REQ-041 SHALL cover: GHR_WIDTH=16, spec_ghr=0xFFFF, accept taken=0 -> 0xFFFE (MSB discarded).
REQ-042 SHALL cover: FETCH_GHR_STALL_STAT_EN defined, 5 WAIT_CP cycles -> ghr_stall_cycles=5; rst -> 0.
